// File: rtl/fp_addsub.sv
// fp_addsub: multi-cycle IEEE-754-style adder/subtractor with subnormal support,
// round-to-nearest-even and {invalid, overflow, inexact} flags behind strobe/ack ports.
module fp_addsub #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [EXP_W+MAN_W:0]   input_a,
    input  logic                   input_a_stb,
    output logic                   input_a_ack,
    input  logic [EXP_W+MAN_W:0]   input_b,
    input  logic                   op_sub,
    input  logic                   input_b_stb,
    output logic                   input_b_ack,
    output logic [EXP_W+MAN_W:0]   output_z,
    output logic [2:0]             output_flags,
    output logic                   output_z_stb,
    input  logic                   output_z_ack,
    output logic                   idle
);
    localparam int W  = 1 + EXP_W + MAN_W;
    // Working significand: hidden bit, fraction, then guard/round/sticky.
    localparam int X  = MAN_W + 4;
    // Biased exponent with headroom for carry and rounding increments.
    localparam int EW = EXP_W + 2;
    localparam logic [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic [EW-1:0] EXP_ALL1 = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]  QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [3:0] {
        GET_A   = 4'd0,
        GET_B   = 4'd1,
        UNPACK  = 4'd2,
        SPECIAL = 4'd3,
        ALIGN   = 4'd4,
        ADD     = 4'd5,
        NORM    = 4'd6,
        ROUND   = 4'd7,
        PACK    = 4'd8,
        PUT_Z   = 4'd9
    } state_t;

    state_t state_r, state_next_s;

    logic           input_a_ack_r, input_b_ack_r, output_z_stb_r, idle_r;
    logic [W-1:0]   z_r;
    logic [2:0]     flags_r;
    logic [W-1:0]   a_r, b_r;
    logic           op_sub_r;
    logic           a_sign_r, b_sign_r, sign_r, inexact_r;
    logic [EW-1:0]  a_exp_r, b_exp_r, exp_r;
    logic [MAN_W:0] a_man_r, b_man_r, rnd_man_r;
    logic [X-1:0]   al_a_r, al_b_r, norm_man_r;
    logic [X:0]     sum_r;

    logic [EXP_W-1:0] a_ef_s, b_ef_s;
    logic [EW-1:0]    a_exp_s, b_exp_s, al_exp_s, norm_exp_s, rnd_exp_s;
    logic [MAN_W:0]   a_man_s, b_man_s, rnd_man_s;
    logic             a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
    logic             spec_hit_s;
    logic [W-1:0]     spec_z_s, pack_z_s;
    logic [2:0]       spec_flags_s, pack_flags_s;
    logic [X-1:0]     al_a_s, al_b_s, norm_man_s;
    logic [X:0]       sum_s;
    logic             sum_sign_s, round_up_s, inexact_s;
    logic [31:0]      lz_s, lim_s, sh_s;
    logic [MAN_W+1:0] rnd_s;

    // Right shift that folds every discarded bit into the sticky LSB.
    function automatic logic [X-1:0] shr_sticky(input logic [X-1:0] v, input logic [EW-1:0] d);
        logic [31:0]  ds;
        logic [X-1:0] sh;
        logic [X-1:0] lost;
        ds   = (32'(d) > 32'(MAN_W + 3)) ? 32'(MAN_W + 3) : 32'(d);
        sh   = v >> ds;
        lost = v & ~({X{1'b1}} << ds);
        return {sh[X-1:1], sh[0] | (|lost)};
    endfunction

    // Count of leading zeros from the MSB of the working significand.
    function automatic logic [31:0] lzc(input logic [X-1:0] v);
        logic [31:0] n;
        logic        found;
        n     = 32'd0;
        found = 1'b0;
        for (int i = X - 1; i >= 0; i--) begin
            if (!found && !v[i]) n = n + 32'd1;
            else                 found = 1'b1;
        end
        return n;
    endfunction

    // Next-state logic for the operation sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            GET_A:   if (input_a_stb && input_a_ack_r) state_next_s = GET_B;  else state_next_s = GET_A;
            GET_B:   if (input_b_stb && input_b_ack_r) state_next_s = UNPACK; else state_next_s = GET_B;
            UNPACK:  state_next_s = SPECIAL;
            SPECIAL: if (spec_hit_s) state_next_s = PUT_Z; else state_next_s = ALIGN;
            ALIGN:   state_next_s = ADD;
            ADD:     state_next_s = NORM;
            NORM:    state_next_s = ROUND;
            ROUND:   state_next_s = PACK;
            PACK:    state_next_s = PUT_Z;
            PUT_Z:   if (output_z_ack) state_next_s = GET_A; else state_next_s = PUT_Z;
            default: state_next_s = GET_A;
        endcase
    end

    // State register and handshake outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r        <= GET_A;
            input_a_ack_r  <= 1'b0;
            input_b_ack_r  <= 1'b0;
            output_z_stb_r <= 1'b0;
            idle_r         <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            input_a_ack_r  <= (state_next_s == GET_A);
            input_b_ack_r  <= (state_next_s == GET_B);
            output_z_stb_r <= (state_next_s == PUT_Z);
            idle_r         <= (state_next_s == GET_A);
        end
    end

    // Field extraction; a zero exponent field is a subnormal at biased exponent 1.
    always_comb begin
        a_ef_s = a_r[W-2:MAN_W];
        b_ef_s = b_r[W-2:MAN_W];
        if (a_ef_s == {EXP_W{1'b0}}) begin
            a_exp_s = EXP_ONE;
            a_man_s = {1'b0, a_r[MAN_W-1:0]};
        end else begin
            a_exp_s = {2'b00, a_ef_s};
            a_man_s = {1'b1, a_r[MAN_W-1:0]};
        end
        if (b_ef_s == {EXP_W{1'b0}}) begin
            b_exp_s = EXP_ONE;
            b_man_s = {1'b0, b_r[MAN_W-1:0]};
        end else begin
            b_exp_s = {2'b00, b_ef_s};
            b_man_s = {1'b1, b_r[MAN_W-1:0]};
        end
    end

    // Special-operand classification and the short-circuit result.
    always_comb begin
        a_nan_s      = (&a_r[W-2:MAN_W]) && (|a_r[MAN_W-1:0]);
        b_nan_s      = (&b_r[W-2:MAN_W]) && (|b_r[MAN_W-1:0]);
        a_inf_s      = (&a_r[W-2:MAN_W]) && !(|a_r[MAN_W-1:0]);
        b_inf_s      = (&b_r[W-2:MAN_W]) && !(|b_r[MAN_W-1:0]);
        a_zero_s     = (a_r[W-2:0] == {(W-1){1'b0}});
        b_zero_s     = (b_r[W-2:0] == {(W-1){1'b0}});
        spec_hit_s   = 1'b0;
        spec_z_s     = {W{1'b0}};
        spec_flags_s = 3'b000;
        if (a_nan_s || b_nan_s) begin
            spec_hit_s   = 1'b1;
            spec_z_s     = QNAN;
            // Only a signalling NaN input raises invalid.
            spec_flags_s = {(a_nan_s && !a_r[MAN_W-1]) || (b_nan_s && !b_r[MAN_W-1]), 2'b00};
        end else if (a_inf_s && b_inf_s && (a_sign_r != b_sign_r)) begin
            spec_hit_s   = 1'b1;
            spec_z_s     = QNAN;
            spec_flags_s = 3'b100;
        end else if (a_inf_s) begin
            spec_hit_s = 1'b1;
            spec_z_s   = {a_sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf_s) begin
            spec_hit_s = 1'b1;
            spec_z_s   = {b_sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero_s && b_zero_s) begin
            spec_hit_s = 1'b1;
            spec_z_s   = {a_sign_r & b_sign_r, {(W-1){1'b0}}};
        end else begin
            spec_hit_s = 1'b0;
        end
    end

    // Alignment of the smaller-exponent operand to the larger exponent.
    always_comb begin
        if (a_exp_r >= b_exp_r) begin
            al_exp_s = a_exp_r;
            al_a_s   = {a_man_r, 3'b000};
            al_b_s   = shr_sticky({b_man_r, 3'b000}, a_exp_r - b_exp_r);
        end else begin
            al_exp_s = b_exp_r;
            al_a_s   = shr_sticky({a_man_r, 3'b000}, b_exp_r - a_exp_r);
            al_b_s   = {b_man_r, 3'b000};
        end
    end

    // Magnitude add or subtract; a difference takes the larger operand's sign.
    always_comb begin
        if (a_sign_r == b_sign_r) begin
            sum_s      = {1'b0, al_a_r} + {1'b0, al_b_r};
            sum_sign_s = a_sign_r;
        end else if (al_a_r >= al_b_r) begin
            sum_s      = {1'b0, al_a_r} - {1'b0, al_b_r};
            sum_sign_s = a_sign_r;
        end else begin
            sum_s      = {1'b0, al_b_r} - {1'b0, al_a_r};
            sum_sign_s = b_sign_r;
        end
    end

    // Normalisation: carry shifts right, otherwise left by the clamped zero count.
    always_comb begin
        lz_s  = lzc(sum_r[X-1:0]);
        lim_s = 32'(exp_r) - 32'd1;
        sh_s  = (lz_s < lim_s) ? lz_s : lim_s;
        if (sum_r[X]) begin
            norm_man_s = {sum_r[X:2], sum_r[1] | sum_r[0]};
            norm_exp_s = exp_r + EXP_ONE;
        end else begin
            norm_man_s = sum_r[X-1:0] << sh_s;
            norm_exp_s = exp_r - EW'(sh_s);
        end
    end

    // Round to nearest, ties to even, on guard/round/sticky.
    always_comb begin
        inexact_s  = norm_man_r[2] | norm_man_r[1] | norm_man_r[0];
        round_up_s = norm_man_r[2] & (norm_man_r[1] | norm_man_r[0] | norm_man_r[3]);
        rnd_s      = {1'b0, norm_man_r[X-1:3]} + {{(MAN_W+1){1'b0}}, round_up_s};
        if (rnd_s[MAN_W+1]) begin
            rnd_man_s = rnd_s[MAN_W+1:1];
            rnd_exp_s = exp_r + EXP_ONE;
        end else begin
            rnd_man_s = rnd_s[MAN_W:0];
            rnd_exp_s = exp_r;
        end
    end

    // Final packing, including exact-cancellation zero and overflow to infinity.
    always_comb begin
        pack_z_s     = {W{1'b0}};
        pack_flags_s = 3'b000;
        if (rnd_man_r == {(MAN_W+1){1'b0}}) begin
            pack_z_s     = {W{1'b0}};
            pack_flags_s = {2'b00, inexact_r};
        end else if (exp_r >= EXP_ALL1) begin
            pack_z_s     = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pack_flags_s = 3'b011;
        end else if (rnd_man_r[MAN_W]) begin
            pack_z_s     = {sign_r, exp_r[EXP_W-1:0], rnd_man_r[MAN_W-1:0]};
            pack_flags_s = {2'b00, inexact_r};
        end else begin
            pack_z_s     = {sign_r, {EXP_W{1'b0}}, rnd_man_r[MAN_W-1:0]};
            pack_flags_s = {2'b00, inexact_r};
        end
    end

    // Datapath registers, each stage loading only in its own state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            z_r        <= {W{1'b0}};
            flags_r    <= 3'b000;
            a_r        <= {W{1'b0}};
            b_r        <= {W{1'b0}};
            op_sub_r   <= 1'b0;
            a_sign_r   <= 1'b0;
            b_sign_r   <= 1'b0;
            sign_r     <= 1'b0;
            inexact_r  <= 1'b0;
            a_exp_r    <= {EW{1'b0}};
            b_exp_r    <= {EW{1'b0}};
            exp_r      <= {EW{1'b0}};
            a_man_r    <= {(MAN_W+1){1'b0}};
            b_man_r    <= {(MAN_W+1){1'b0}};
            rnd_man_r  <= {(MAN_W+1){1'b0}};
            al_a_r     <= {X{1'b0}};
            al_b_r     <= {X{1'b0}};
            norm_man_r <= {X{1'b0}};
            sum_r      <= {(X+1){1'b0}};
        end else begin
            case (state_r)
                GET_A: if (input_a_stb && input_a_ack_r) a_r <= input_a;
                GET_B: if (input_b_stb && input_b_ack_r) begin
                    b_r      <= input_b;
                    op_sub_r <= op_sub;
                end
                UNPACK: begin
                    a_sign_r <= a_r[W-1];
                    b_sign_r <= b_r[W-1] ^ op_sub_r;
                    a_exp_r  <= a_exp_s;
                    b_exp_r  <= b_exp_s;
                    a_man_r  <= a_man_s;
                    b_man_r  <= b_man_s;
                end
                SPECIAL: if (spec_hit_s) begin
                    z_r     <= spec_z_s;
                    flags_r <= spec_flags_s;
                end
                ALIGN: begin
                    al_a_r <= al_a_s;
                    al_b_r <= al_b_s;
                    exp_r  <= al_exp_s;
                end
                ADD: begin
                    sum_r  <= sum_s;
                    sign_r <= sum_sign_s;
                end
                NORM: begin
                    norm_man_r <= norm_man_s;
                    exp_r      <= norm_exp_s;
                end
                ROUND: begin
                    rnd_man_r <= rnd_man_s;
                    exp_r     <= rnd_exp_s;
                    inexact_r <= inexact_s;
                end
                PACK: begin
                    z_r     <= pack_z_s;
                    flags_r <= pack_flags_s;
                end
                default: begin
                    z_r <= z_r;
                end
            endcase
        end
    end

    assign input_a_ack  = input_a_ack_r;
    assign input_b_ack  = input_b_ack_r;
    assign output_z_stb = output_z_stb_r;
    assign output_z     = z_r;
    assign output_flags = flags_r;
    assign idle         = idle_r;

endmodule

// File: doc/fp_addsub.md
# fp_addsub

Parametrised IEEE-754-style floating-point adder/subtractor, successor to the single-precision `adder`. Operand width is set by exponent and mantissa parameters, and an operation bit selects add or subtract. It also supports subnormals, produces round-to-nearest-even results, reports exception flags, and has a fixed latency. It sits in the FPU datapath behind per-operand strobe/ack handshakes, with a strobe/ack result port.

## Interface
- `EXP_W`, 8: exponent field width (≥3).
- `MAN_W`, 23: stored mantissa field width (≥2). Word width W = 1+EXP_W+MAN_W.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-low; effective on any rising edge of `clk` where `rst`=0.
- `input_a` in W: operand A.
- `input_a_stb` in 1: A valid.
- `input_a_ack` out 1: A accepted.
- `input_b` in W: operand B.
- `op_sub` in 1: sampled with B; 1 = A−B, 0 = A+B.
- `input_b_stb` in 1: B valid.
- `input_b_ack` out 1: B accepted.
- `output_z` out W: result.
- `output_flags` out 3: {invalid, overflow, inexact}, valid with `output_z`.
- `output_z_stb` out 1: result valid.
- `output_z_ack` in 1: consumer accepted result.
- `idle` out 1: high when waiting for A.

## Operation
- FSM: GET_A → GET_B → UNPACK → SPECIAL → ALIGN → ADD → NORM → ROUND → PACK → PUT_Z → GET_A. SPECIAL jumps directly to PUT_Z for special operands.
- Handshake rules:
  - `input_a_ack`=1 only in GET_A; `input_b_ack`=1 only in GET_B.
  - A transfer occurs on an edge where stb&ack=1.
  - Acks are registered and drop the cycle after transfer.
  - `output_z_stb`=1 only in PUT_Z; `output_z`/`output_flags` are held stable until `output_z_ack`=1.
- UNPACK: exponent field 0 → subnormal, effective exponent 1−bias, no hidden bit. B's sign is inverted when `op_sub`=1.
- SPECIAL, checked in priority order:
  - NaN in either operand → canonical quiet NaN (sign 0, exp all-1, mantissa MSB 1, rest 0); invalid=1 only if some input NaN has mantissa MSB 0.
  - Inf + (−Inf) effective → canonical NaN, invalid=1.
  - Otherwise Inf → that Inf.
  - Both zero → −0 if both effective signs are negative, else +0.
- ALIGN: single-cycle barrel shift of the smaller-exponent mantissa, extended with guard, round and sticky bits. Shift saturates at MAN_W+3, and every bit shifted out ORs into sticky.
- ADD: same effective signs add magnitudes; different signs subtract smaller from larger, and the result takes the larger operand's sign.
- NORM: carry-out → right shift 1, exponent+1, sticky accumulates. Otherwise a leading-zero shift left, clamped so exponent ≥ 1−bias (subnormal result).
- ROUND: round to nearest, ties to even; inexact = guard|round|sticky. Mantissa carry from rounding increments the exponent.
- Exact zero from cancellation → +0.
- Overflow: exponent ≥ all-1 → ±Inf, overflow=1, inexact=1.
- `rst`=0 at any state → GET_A on that edge, abandoning the in-flight operation. Reset values: `input_a_ack`=0, `input_b_ack`=0, `output_z_stb`=0, `output_z`=0, `output_flags`=0, `idle`=0. First edge after reset release enters GET_A; `input_a_ack`/`idle` go to 1.

## Timing
- Take edge N as the B transfer edge.
- Normal path: UNPACK..PACK occupy N+1..N+7. `output_z_stb` rises after edge N+7, so latency is 7 cycles.
- Special path: `output_z_stb` rises after edge N+2.
- After the edge where `output_z_stb`&`output_z_ack`=1: `output_z_stb`=0, `input_a_ack`=1, `idle`=1.
- A held back-to-back: next A transfer occurs one cycle after Z transfer. Minimum normal throughput is 1 result per 10 cycles.
- `input_b_stb` asserted early is ignored until GET_B. `output_z_ack` outside PUT_Z is ignored.

## Test plan
- Defaults, A=0x433E95C3 (190.585), B=0x40E80000 (7.25), op_sub=0 → Z=0x4345D5C3, flags=000, strobe exactly 7 cycles after B transfer.
- A=0x40400000, B=0x3F800000, op_sub=1 → 0x40000000. A=0x3F800000, B=0xBF800000, add → 0x00000000 (+0). 0x80000000+0x80000000 → 0x80000000.
- A=0x3F800000 + B=0x33800000 (tie) → 0x3F800000, inexact=1. 0x00000001+0x00000001 → 0x00000002, flags 000.
- 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000, flags 011. 0x7F800000 − 0x7F800000 → 0x7FC00000, flags 100, strobe 2 cycles after B.
- Hold `output_z_ack`=0 for 20 cycles → Z and flags stable, no ack on A/B. Pulse `rst`=0 during ALIGN → all outputs 0 next cycle, then GET_A, and the next operation is correct.
- EXP_W=5, MAN_W=10: 0x3C00+0x3C00 → 0x4000. 0x7BFF+0x7BFF → 0x7C00, overflow=1.
